// File: rtl/layer3_weight_sched_pkg.sv
// rtl/layer3_weight_sched_pkg.sv - shared state encoding and default per-conv weight counts
package layer3_sched_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_L1   = 3'd1,
    ST_L2   = 3'd2,
    ST_L3   = 3'd3,
    ST_L4   = 3'd4,
    ST_FIN  = 3'd5
  } state_t;

  localparam int N_W1_DEF  = 131072;
  localparam int N_W2_DEF  = 589824;
  localparam int N_W3_DEF  = 262144;
  localparam int N_W4_DEF  = 524288;
  localparam int CNT_W_DEF = 20;

endpackage

// File: rtl/layer3_weight_sched_if.sv
// rtl/layer3_weight_sched_if.sv - upstream weight stream plus the four demuxed conv weight ports
interface layer3_weight_sched_if #(
  parameter int DATA_WIDTH = 32
);

  logic                  valid_in;
  logic [DATA_WIDTH-1:0] weight_in;
  logic                  ready_out;
  logic                  valid_weight_out1;
  logic                  valid_weight_out2;
  logic                  valid_weight_out3;
  logic                  valid_weight_out4;
  logic [DATA_WIDTH-1:0] weight_out1;
  logic [DATA_WIDTH-1:0] weight_out2;
  logic [DATA_WIDTH-1:0] weight_out3;
  logic [DATA_WIDTH-1:0] weight_out4;

  modport master (
    output valid_in, weight_in,
    input  ready_out,
    input  valid_weight_out1, valid_weight_out2, valid_weight_out3, valid_weight_out4,
    input  weight_out1, weight_out2, weight_out3, weight_out4
  );

  modport slave (
    input  valid_in, weight_in,
    output ready_out,
    output valid_weight_out1, valid_weight_out2, valid_weight_out3, valid_weight_out4,
    output weight_out1, weight_out2, weight_out3, weight_out4
  );

endinterface

// File: rtl/layer3_weight_sched_word_counter.sv
// rtl/layer3_weight_sched_word_counter.sv - per-conv word counter; last flags the final accepted word
module wsched_word_counter #(
  parameter int CNT_W = 20
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             clr,
  input  logic [CNT_W-1:0] limit,
  output logic             last
);

  logic [CNT_W-1:0] cnt;

  assign last = inc && (cnt == limit - CNT_W'(1));

  // Self-clearing on the final word so the next conv starts from zero without wrapping.
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      cnt <= '0;
    end else if (last) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/layer3_weight_sched.sv
// rtl/layer3_weight_sched.sv - sequences one weight stream into conv1..conv4 ports with a done pulse
// Optional running XOR checksum output under LAYER3_WSCHED_CHECKSUM_EN.
module layer3_weight_sched
  import layer3_sched_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int N_W1       = N_W1_DEF,
  parameter int N_W2       = N_W2_DEF,
  parameter int N_W3       = N_W3_DEF,
  parameter int N_W4       = N_W4_DEF,
  parameter int CNT_W      = CNT_W_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
`ifdef LAYER3_WSCHED_CHECKSUM_EN
  output logic [DATA_WIDTH-1:0] checksum,
`endif
  layer3_weight_sched_if.slave  wif
);

  state_t           state;
  logic             hs;
  logic             last;
  logic [CNT_W-1:0] limit;

  assign wif.ready_out = (state == ST_L1) || (state == ST_L2) ||
                         (state == ST_L3) || (state == ST_L4);
  assign hs = wif.valid_in && wif.ready_out;

  always_comb begin
    limit = CNT_W'(N_W1);
    case (state)
      ST_L2:   limit = CNT_W'(N_W2);
      ST_L3:   limit = CNT_W'(N_W3);
      ST_L4:   limit = CNT_W'(N_W4);
      default: limit = CNT_W'(N_W1);
    endcase
  end

  wsched_word_counter #(
    .CNT_W (CNT_W)
  ) u_word_counter (
    .clk   (clk),
    .reset (reset),
    .inc   (hs),
    .clr   ((state == ST_IDLE) || (state == ST_FIN)),
    .limit (limit),
    .last  (last)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state                 <= ST_IDLE;
      busy                  <= 1'b0;
      done                  <= 1'b0;
      wif.valid_weight_out1 <= 1'b0;
      wif.valid_weight_out2 <= 1'b0;
      wif.valid_weight_out3 <= 1'b0;
      wif.valid_weight_out4 <= 1'b0;
      wif.weight_out1       <= '0;
      wif.weight_out2       <= '0;
      wif.weight_out3       <= '0;
      wif.weight_out4       <= '0;
    end else begin
      done                  <= 1'b0;
      wif.valid_weight_out1 <= 1'b0;
      wif.valid_weight_out2 <= 1'b0;
      wif.valid_weight_out3 <= 1'b0;
      wif.valid_weight_out4 <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (start) begin
            state <= ST_L1;
            busy  <= 1'b1;
          end
        end
        ST_L1: if (last) state <= ST_L2;
        ST_L2: if (last) state <= ST_L3;
        ST_L3: if (last) state <= ST_L4;
        ST_L4: begin
          if (last) begin
            state <= ST_FIN;
            done  <= 1'b1;
          end
        end
        ST_FIN: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase

      // Weight registers only load on a handshake so they hold across stalls.
      if (hs) begin
        case (state)
          ST_L1: begin
            wif.weight_out1       <= wif.weight_in;
            wif.valid_weight_out1 <= 1'b1;
          end
          ST_L2: begin
            wif.weight_out2       <= wif.weight_in;
            wif.valid_weight_out2 <= 1'b1;
          end
          ST_L3: begin
            wif.weight_out3       <= wif.weight_in;
            wif.valid_weight_out3 <= 1'b1;
          end
          ST_L4: begin
            wif.weight_out4       <= wif.weight_in;
            wif.valid_weight_out4 <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

`ifdef LAYER3_WSCHED_CHECKSUM_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      checksum <= '0;
    end else if ((state == ST_IDLE) && start) begin
      checksum <= '0;
    end else if (hs) begin
      checksum <= checksum ^ wif.weight_in;
    end
  end
`endif

endmodule

// File: tb/tb_layer3_weight_sched.sv
// tb/tb_layer3_weight_sched.sv - randomized self-checking bench for layer3_weight_sched (N_W = 4,9,4,8)
module tb_layer3_weight_sched;

  localparam int DW    = 32;
  localparam int TOTAL = 25;

  logic clk = 1'b0;
  logic reset;
  logic start;
  logic busy;
  logic done;
`ifdef LAYER3_WSCHED_CHECKSUM_EN
  logic [DW-1:0] checksum;
`endif

  layer3_weight_sched_if #(.DATA_WIDTH(DW)) wif ();

  layer3_weight_sched #(
    .DATA_WIDTH (DW),
    .N_W1       (4),
    .N_W2       (9),
    .N_W3       (4),
    .N_W4       (8),
    .CNT_W      (20)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .busy     (busy),
    .done     (done),
`ifdef LAYER3_WSCHED_CHECKSUM_EN
    .checksum (checksum),
`endif
    .wif      (wif)
  );

  always #5 clk = ~clk;

  int nw[4] = '{4, 9, 4, 8};
  logic [DW-1:0] words[TOTAL];
  logic [DW-1:0] qp[4][$];
  int rdy_cycles, done_pulses, busy_bad, multi_valid;
  logic prev_done = 1'b0;
  int pass_cnt = 0;
  int total_cnt = 0;

  always @(negedge clk) begin
    int nv;
    nv = 0;
    if (wif.valid_weight_out1) begin qp[0].push_back(wif.weight_out1); nv++; end
    if (wif.valid_weight_out2) begin qp[1].push_back(wif.weight_out2); nv++; end
    if (wif.valid_weight_out3) begin qp[2].push_back(wif.weight_out3); nv++; end
    if (wif.valid_weight_out4) begin qp[3].push_back(wif.weight_out4); nv++; end
    if (nv > 1) multi_valid++;
    if (wif.ready_out) rdy_cycles++;
    if (done) begin
      done_pulses++;
      if (!busy) busy_bad++;
    end
    if (prev_done && busy) busy_bad++;
    prev_done = done;
  end

  task automatic clear_monitor();
    for (int k = 0; k < 4; k++) qp[k].delete();
    rdy_cycles  = 0;
    done_pulses = 0;
    busy_bad    = 0;
    multi_valid = 0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b1;
    wif.valid_in  = 1'b1;
    wif.weight_in = '1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total_cnt++;
    if ({busy, done, wif.ready_out} !== 3'b000)
      $display("FAIL reset_ctrl: busy/done/ready got %b expected 000", {busy, done, wif.ready_out});
    else pass_cnt++;
    total_cnt++;
    if ({wif.valid_weight_out1, wif.valid_weight_out2, wif.valid_weight_out3, wif.valid_weight_out4} !== 4'b0)
      $display("FAIL reset_valid: got %b expected 0000",
               {wif.valid_weight_out1, wif.valid_weight_out2, wif.valid_weight_out3, wif.valid_weight_out4});
    else pass_cnt++;
    total_cnt++;
    if ((wif.weight_out1 | wif.weight_out2 | wif.weight_out3 | wif.weight_out4) !== '0)
      $display("FAIL reset_weights: or-reduced got %h expected 0",
               wif.weight_out1 | wif.weight_out2 | wif.weight_out3 | wif.weight_out4);
    else pass_cnt++;
`ifdef LAYER3_WSCHED_CHECKSUM_EN
    total_cnt++;
    if (checksum !== '0) $display("FAIL reset_checksum: got %h expected 0", checksum);
    else pass_cnt++;
`endif
    @(posedge clk); #1;
    reset = 1'b0;
    start = 1'b0;
    wif.valid_in = 1'b0;
    @(negedge clk);
    total_cnt++;
    if (busy !== 1'b0) $display("FAIL reset_wins_start: busy got %b expected 0", busy);
    else pass_cnt++;
  endtask

  // mode 0: valid held high, mode 1: 1010 toggling with words 1..25, mode 2: random stalls.
  task automatic test_load(input int mode, input bit mid_start, input string tag);
    int idx, cyc;
    bit hs, mid_done, vld;
    logic [DW-1:0] exp_xor;
    int off;
    bit ok;
    exp_xor  = '0;
    idx      = 0;
    cyc      = 0;
    mid_done = 1'b0;
    for (int i = 0; i < TOTAL; i++) begin
      words[i] = (mode == 1) ? DW'(i + 1) : DW'($urandom);
      exp_xor ^= words[i];
    end
    @(posedge clk); #1;
    clear_monitor();
    start = 1'b1;
    wif.valid_in  = 1'b1;
    wif.weight_in = words[0];
    while (done_pulses == 0 && cyc < 600) begin
      @(negedge clk);
      hs = wif.valid_in && wif.ready_out;
      @(posedge clk); #1;
      start = 1'b0;
      if (hs) idx++;
      cyc++;
      if (mid_start && !mid_done && idx == 6) begin
        start    = 1'b1;
        mid_done = 1'b1;
      end
      case (mode)
        0:       vld = 1'b1;
        1:       vld = (cyc % 2) == 0;
        default: vld = ($urandom_range(0, 3) != 0);
      endcase
      wif.valid_in  = vld && (idx < TOTAL);
      wif.weight_in = (idx < TOTAL) ? words[idx] : $urandom;
    end
    wif.valid_in = 1'b0;
    repeat (3) @(negedge clk);

    total_cnt++;
    if (cyc >= 600) $display("FAIL %s timeout: cycles %0d expected done before 600", tag, cyc);
    else pass_cnt++;
    total_cnt++;
    if (done_pulses !== 1) $display("FAIL %s done_pulses: got %0d expected 1", tag, done_pulses);
    else pass_cnt++;
    total_cnt++;
    if (idx !== TOTAL) $display("FAIL %s words_consumed: got %0d expected %0d", tag, idx, TOTAL);
    else pass_cnt++;
    off = 0;
    for (int k = 0; k < 4; k++) begin
      total_cnt++;
      ok = (qp[k].size() == nw[k]);
      if (ok)
        for (int j = 0; j < nw[k]; j++)
          if (qp[k][j] !== words[off + j]) ok = 1'b0;
      if (!ok)
        $display("FAIL %s port%0d: got %0d words (first %h) expected %0d words (first %h)",
                 tag, k + 1, qp[k].size(), (qp[k].size() > 0) ? qp[k][0] : '0, nw[k], words[off]);
      else pass_cnt++;
      off += nw[k];
    end
    total_cnt++;
    if (multi_valid !== 0) $display("FAIL %s one_hot_valid: got %0d overlaps expected 0", tag, multi_valid);
    else pass_cnt++;
    total_cnt++;
    if (busy_bad !== 0 || busy !== 1'b0)
      $display("FAIL %s busy_vs_done: got %0d bad cycles busy=%b expected 0 and 0", tag, busy_bad, busy);
    else pass_cnt++;
    if (mode == 0) begin
      total_cnt++;
      if (rdy_cycles !== TOTAL) $display("FAIL %s ready_cycles: got %0d expected %0d", tag, rdy_cycles, TOTAL);
      else pass_cnt++;
    end
`ifdef LAYER3_WSCHED_CHECKSUM_EN
    total_cnt++;
    if (checksum !== exp_xor) $display("FAIL %s checksum: got %h expected %h", tag, checksum, exp_xor);
    else pass_cnt++;
`endif
  endtask

  task automatic test_reset_mid_load();
    int idx, cyc;
    bit hs;
    @(posedge clk); #1;
    clear_monitor();
    idx = 0;
    cyc = 0;
    start = 1'b1;
    wif.valid_in  = 1'b1;
    wif.weight_in = DW'($urandom);
    while (idx < 15 && cyc < 100) begin
      @(negedge clk);
      hs = wif.valid_in && wif.ready_out;
      @(posedge clk); #1;
      start = 1'b0;
      if (hs) idx++;
      cyc++;
      wif.weight_in = DW'($urandom);
    end
    reset = 1'b1;
    wif.valid_in = 1'b0;
    @(posedge clk);
    @(negedge clk);
    total_cnt++;
    if ({busy, done, wif.ready_out} !== 3'b000)
      $display("FAIL midreset_ctrl: busy/done/ready got %b expected 000", {busy, done, wif.ready_out});
    else pass_cnt++;
    total_cnt++;
    if (({wif.valid_weight_out1, wif.valid_weight_out2, wif.valid_weight_out3, wif.valid_weight_out4} !== 4'b0) ||
        ((wif.weight_out1 | wif.weight_out2 | wif.weight_out3 | wif.weight_out4) !== '0))
      $display("FAIL midreset_outputs: valid %b weights-or %h expected 0",
               {wif.valid_weight_out1, wif.valid_weight_out2, wif.valid_weight_out3, wif.valid_weight_out4},
               wif.weight_out1 | wif.weight_out2 | wif.weight_out3 | wif.weight_out4);
    else pass_cnt++;
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (5) @(negedge clk);
    total_cnt++;
    if (done_pulses !== 0) $display("FAIL midreset_no_done: got %0d expected 0", done_pulses);
    else pass_cnt++;
    test_load(2, 1'b0, "after_midreset");
  endtask

  task automatic test_idle_valid();
    @(posedge clk); #1;
    clear_monitor();
    wif.valid_in  = 1'b1;
    wif.weight_in = DW'($urandom);
    repeat (10) @(posedge clk);
    #1;
    wif.valid_in = 1'b0;
    @(negedge clk);
    total_cnt++;
    if (rdy_cycles !== 0 || busy !== 1'b0)
      $display("FAIL idle_ready: ready cycles %0d busy %b expected 0 and 0", rdy_cycles, busy);
    else pass_cnt++;
    total_cnt++;
    if (qp[0].size() + qp[1].size() + qp[2].size() + qp[3].size() !== 0)
      $display("FAIL idle_valid_out: got %0d pulses expected 0",
               qp[0].size() + qp[1].size() + qp[2].size() + qp[3].size());
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    int cyc;
    @(posedge clk); #1;
    clear_monitor();
    cyc = 0;
    start = 1'b1;
    wif.valid_in  = 1'b1;
    wif.weight_in = DW'($urandom);
    @(posedge clk); #1;
    start = 1'b0;
    while (cyc < 100) begin
      @(negedge clk);
      if (done) break;
      @(posedge clk); #1;
      wif.weight_in = DW'($urandom);
      cyc++;
    end
    total_cnt++;
    if (done !== 1'b1) $display("FAIL b2b_reach_fin: done got %b expected 1", done);
    else pass_cnt++;
    // Still inside the FIN cycle: this start must be dropped.
    start = 1'b1;
    wif.valid_in = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    total_cnt++;
    if (busy !== 1'b0) $display("FAIL b2b_start_in_fin: busy got %b expected 0", busy);
    else pass_cnt++;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    total_cnt++;
    if (busy !== 1'b1 || wif.ready_out !== 1'b1)
      $display("FAIL b2b_start_after_fin: busy %b ready %b expected 1 and 1", busy, wif.ready_out);
    else pass_cnt++;
`ifdef LAYER3_WSCHED_CHECKSUM_EN
    total_cnt++;
    if (checksum !== '0) $display("FAIL b2b_checksum_clear: got %h expected 0", checksum);
    else pass_cnt++;
`endif
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

`ifdef LAYER3_WSCHED_CHECKSUM_EN
  task automatic test_checksum();
    test_load(1, 1'b0, "checksum_seq");
    total_cnt++;
    if (checksum !== 32'd1) $display("FAIL checksum_1_to_25: got %h expected 00000001", checksum);
    else pass_cnt++;
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    total_cnt++;
    if (checksum !== '0) $display("FAIL checksum_clear_on_start: got %h expected 0", checksum);
    else pass_cnt++;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask
`endif

  initial begin
    reset = 1'b1;
    start = 1'b0;
    wif.valid_in  = 1'b0;
    wif.weight_in = '0;
    clear_monitor();
    test_reset();
    test_load(0, 1'b0, "held_valid");
    test_load(1, 1'b0, "toggle_valid");
    test_load(0, 1'b1, "start_mid_l2");
    test_reset_mid_load();
    test_idle_valid();
    for (int r = 0; r < 3; r++) test_load(2, 1'b0, "random_stalls");
    test_back_to_back();
`ifdef LAYER3_WSCHED_CHECKSUM_EN
    test_checksum();
`endif
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
